// File: rtl/multicycle_control.sv
// multicycle_control: Moore main control FSM sequencing the multi-cycle MIPS datapath
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  state_t state, next;
  assign State = state;
  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= next;
  // next-state selection; memory states stall until MemReady
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:  next = MemReady ? DECODE : FETCH;
      DECODE: next = Opcode == OP_R    ? EXEC   :
                     Opcode == OP_LW   ? MEMADR :
                     Opcode == OP_SW   ? MEMADR :
                     Opcode == OP_BEQ  ? BRANCH :
                     Opcode == OP_J    ? JUMP   :
                     Opcode == OP_ADDI ? ADDIEX : FETCH;
      MEMADR: next = Opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:  next = MemReady ? MEMWB : MEMRD;
      MEMWR:  next = MemReady ? FETCH : MEMWR;
      EXEC:   next = ALUWB;
      ADDIEX: next = ADDIWB;
      default: next = FETCH;
    endcase
  end
  // control outputs decoded from state, all forced low while reset is held
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite = 1'b0;
    ALUSrcA = 1'b0;
    RegWrite = 1'b0;
    RegDst = 1'b0;
    PCSource = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    IllegalOp = 1'b0;
    if (!reset)
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          IllegalOp = !(Opcode == OP_R || Opcode == OP_LW || Opcode == OP_SW ||
                        Opcode == OP_BEQ || Opcode == OP_J || Opcode == OP_ADDI);
        end
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp = 2'b10;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          RegDst = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp = 2'b01;
          PCWriteCond = 1'b1;
          PCSource = 2'b01;
        end
        JUMP: begin
          PCWrite = 1'b1;
          PCSource = 2'b10;
        end
        ADDIWB: RegWrite = 1'b1;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for the multi-cycle control FSM
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic MemReady = 1'b1;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic ALUSrcA, RegWrite, RegDst, IllegalOp;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] State;
  logic [16:0] ctrl;
  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, IllegalOp};

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,ALUOp,IllegalOp}
  localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FRDY   = 17'b1_0_0_1_0_0_1_0_0_0_00_01_00_0;
  localparam logic [16:0] C_FSTALL = 17'b0_0_0_1_0_0_0_0_0_0_00_01_00_0;
  localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_0;
  localparam logic [16:0] C_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_1;
  localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_1_0_0_00_00_10_0;
  localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_0_0_0_1_1_00_00_00_0;
  localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_1_0_0_01_00_01_0;
  localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_0;
  localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  task automatic test_reset;
    MemReady = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (State !== 4'd0 || ctrl !== C_ZERO) begin
      errors++;
      $display("FAIL reset_hold state=%0d ctrl=%h expected state=0 ctrl=%h", State, ctrl, C_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0 || ctrl !== C_FRDY) begin
      errors++;
      $display("FAIL reset_release state=%0d ctrl=%h expected state=0 ctrl=%h", State, ctrl, C_FRDY);
    end
    MemReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rtype;
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    logic [16:0] cv [4] = '{C_FRDY, C_DEC, C_EXEC, C_ALUWB};
    Opcode = R;
    for (int i = 0; i < 4; i++) begin
      MemReady = 1'b1;
      #1;
      checks++;
      if (State !== st[i] || ctrl !== cv[i]) begin
        errors++;
        $display("FAIL rtype[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, State, ctrl, st[i], cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_stall;
    logic [3:0] st [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic mr [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [5:0] op [7] = '{LW, LW, LW, BAD, R, SW, BAD};
    logic [16:0] cv [7] = '{C_FRDY, C_DEC, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
    for (int i = 0; i < 7; i++) begin
      MemReady = mr[i];
      Opcode = op[i];
      #1;
      checks++;
      if (State !== st[i] || ctrl !== cv[i]) begin
        errors++;
        $display("FAIL lw_stall[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, State, ctrl, st[i], cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] st [12] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0};
    logic mr [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0] op [12] = '{SW, SW, SW, LW, BEQ, BEQ, R, J, J, BAD, R, R};
    logic [16:0] cv [12] = '{C_FRDY, C_DEC, C_MEMADR, C_MEMWR, C_FRDY, C_DEC, C_BRANCH,
                             C_FRDY, C_DEC, C_JUMP, C_FSTALL, C_FSTALL};
    for (int i = 0; i < 12; i++) begin
      MemReady = mr[i];
      Opcode = op[i];
      #1;
      checks++;
      if (State !== st[i] || ctrl !== cv[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, State, ctrl, st[i], cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_stall;
    logic [3:0] st [7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd9, 4'd0};
    logic mr [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [16:0] cv [7] = '{C_FSTALL, C_FSTALL, C_FSTALL, C_FRDY, C_DEC, C_JUMP, C_FSTALL};
    Opcode = J;
    for (int i = 0; i < 7; i++) begin
      MemReady = mr[i];
      #1;
      checks++;
      if (State !== st[i] || ctrl !== cv[i]) begin
        errors++;
        $display("FAIL fetch_stall[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, State, ctrl, st[i], cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_addi_illegal;
    logic [3:0] st [7] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd1, 4'd0};
    logic mr [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] op [7] = '{ADDI, ADDI, ADDI, ADDI, BAD, BAD, BAD};
    logic [16:0] cv [7] = '{C_FRDY, C_DEC, C_MEMADR, C_ADDIWB, C_FRDY, C_DECILL, C_FSTALL};
    for (int i = 0; i < 7; i++) begin
      MemReady = mr[i];
      Opcode = op[i];
      #1;
      checks++;
      if (State !== st[i] || ctrl !== cv[i]) begin
        errors++;
        $display("FAIL addi_illegal[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, State, ctrl, st[i], cv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_exec;
    Opcode = R;
    MemReady = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (State !== 4'd6 || ctrl !== C_EXEC) begin
      errors++;
      $display("FAIL pre_reset_exec state=%0d ctrl=%h expected state=6 ctrl=%h", State, ctrl, C_EXEC);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0 || ctrl !== C_ZERO) begin
      errors++;
      $display("FAIL async_reset state=%0d ctrl=%h expected state=0 ctrl=%h", State, ctrl, C_ZERO);
    end
    @(negedge clk);
    #1;
    checks++;
    if (State !== 4'd0 || ctrl !== C_ZERO) begin
      errors++;
      $display("FAIL reset_no_wb state=%0d ctrl=%h expected state=0 ctrl=%h", State, ctrl, C_ZERO);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0 || ctrl !== C_FRDY) begin
      errors++;
      $display("FAIL reset_to_fetch state=%0d ctrl=%h expected state=0 ctrl=%h", State, ctrl, C_FRDY);
    end
    @(negedge clk);
    #1;
    checks++;
    if (State !== 4'd1 || ctrl !== C_DEC) begin
      errors++;
      $display("FAIL after_reset_decode state=%0d ctrl=%h expected state=1 ctrl=%h", State, ctrl, C_DEC);
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_lw_stall;
    test_back_to_back;
    test_fetch_stall;
    test_addi_illegal;
    test_reset_mid_exec;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back over 3–5 cycles, using the opcode from the instruction register. It drives every datapath enable and mux select, plus the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 subtract, 10 decode funct). Memory states stall on a ready handshake.

## Interface
- No parameters; state encoding and opcodes fixed below.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- Opcode  in  6  IR[31:26], valid from DECODE onward
- MemReady  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  to ALU control decoder
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode
- State  out  4  current state, for debug/verification

## Operation
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 go to FETCH next cycle with all outputs 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- Unlisted outputs are 0 in every state.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00; IRWrite=PCWrite=MemReady. Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state: R→EXEC, lw/sw→MEMADR, beq→BRANCH, j→JUMP, addi→ADDIEX. Any other opcode: IllegalOp=1, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw→MEMRD, sw→MEMWR, using the Opcode value held since DECODE.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.

## Timing
- Outputs are combinational from State. The only exception is MemReady qualifying IRWrite and PCWrite in FETCH.
- While reset=1: State=0 and every output is 0, including IRWrite, PCWrite and MemRead. This overrides the FETCH decode.
- After reset falls, the first rising edge is evaluated in FETCH.
- Reset asserted mid-instruction aborts it immediately and asynchronously. No partial write-back follows.
- Cycles per instruction with MemReady tied high: beq 3, j 3, R 4, sw 4, addi 4, lw 5, illegal 2.
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs hold their values during the stall.
- MemReady is ignored in all other states.
- Opcode changing outside DECODE/MEMADR has no effect.
- IllegalOp is high for exactly the one DECODE cycle.

## Test plan
- Reset mid-EXEC: assert reset asynchronously → State=0 and all outputs 0 before the next edge. Release reset → FETCH with MemRead=1, ALUSrcB=01.
- R-type, MemReady=1: State sequence 0,1,6,7,0. ALUOp=10 in EXEC; RegWrite=1, RegDst=1 in ALUWB.
- lw with MemReady low for 2 cycles in MEMRD: State 0,1,2,3,3,3,4,0 (7 cycles). MemRead=1 and IorD=1 throughout MEMRD; MemtoReg=1 in MEMWB.
- sw, then beq, then j back-to-back: sw 0,1,2,5,0 with MemWrite=1 only in MEMWR. beq 0,1,8,0 with ALUOp=01, PCWriteCond=1, PCSource=01. j 0,1,9,0 with PCWrite=1, PCSource=10.
- FETCH stall: MemReady=0 for 3 cycles → State stays 0 with IRWrite=PCWrite=0. The cycle MemReady=1: IRWrite=PCWrite=1, then DECODE.
- addi 0,1,10,11,0, then Opcode=111111: IllegalOp=1 for one cycle in DECODE, return to FETCH, RegWrite never asserted.
